// File: rtl/pipelined_memory.sv
// pipelined_memory: single-clock word array with a self-clearing FSM and a
// fully pipelined read path of one or two register stages.
// After reset, or on a clear request, every address is zeroed one per cycle
// while ready is low. User reads and writes are accepted only while ready is high.
module pipelined_memory #(
    parameter int DEPTH        = 8,
    parameter int BIT_SIZE     = 16,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_enable,
    input  logic [DEPTH-1:0]    write_addr,
    input  logic [BIT_SIZE-1:0] data_in,
    input  logic                read_enable,
    input  logic [DEPTH-1:0]    read_addr,
    input  logic                clear,
    output logic [BIT_SIZE-1:0] data_out,
    output logic                data_valid,
    output logic                ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH-1:0]     count_q, count_d;

    logic [BIT_SIZE-1:0]  mem [2**DEPTH];

    logic                 mem_we;
    logic [DEPTH-1:0]     mem_waddr;
    logic [BIT_SIZE-1:0]  mem_wdata;

    logic                 wr_acc;
    logic                 rd_acc;
    logic [BIT_SIZE-1:0]  rd_word;

    logic                 s1_valid_q, s1_valid_d;
    logic [BIT_SIZE-1:0]  s1_data_q, s1_data_d;

    assign ready  = (state_q == READY);
    assign wr_acc = write_enable && ready;
    assign rd_acc = read_enable && ready;

    // Next-state logic: clear sweep owns the write port; otherwise user writes pass through.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = data_in;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = count_q;
                mem_wdata = '0;
                if (count_q == {DEPTH{1'b1}}) begin
                    state_d = READY;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            READY: begin
                mem_we = wr_acc;
                if (clear) begin
                    state_d = CLEAR;
                    count_d = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                count_d = '0;
            end
        endcase
    end

    // FSM state and clear counter; reset restarts the sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Array storage; contents are zeroed by the clear sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read word selection, forwarding same-address write data when bypass is enabled.
    always_comb begin
        rd_word = mem[read_addr];
        if ((BYPASS != 0) && wr_acc && (write_addr == read_addr)) begin
            rd_word = data_in;
        end
        s1_valid_d = rd_acc;
        s1_data_d  = rd_acc ? rd_word : s1_data_q;
    end

    // First read stage: samples the array at the accepting edge and holds data between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                s2_valid_q, s2_valid_d;
            logic [BIT_SIZE-1:0] s2_data_q, s2_data_d;

            // Second stage forwards valid and captures data only on a valid first-stage word.
            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
            end

            // Extra output register carrying both data and valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign data_out   = s2_data_q;
            assign data_valid = s2_valid_q;
        end else begin : g_lat1
            assign data_out   = s1_data_q;
            assign data_valid = s1_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory: directed bench driving two instances from the same inputs.
// Instance A: READ_LATENCY=2, BYPASS=1. Instance B: READ_LATENCY=1, BYPASS=0.
module tb_pipelined_memory;

    logic       clk;
    logic       rst_n;
    logic       write_enable;
    logic [3:0] write_addr;
    logic [7:0] data_in;
    logic       read_enable;
    logic [3:0] read_addr;
    logic       clear;

    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b;
    logic       ready_a, ready_b;

    int total = 0;
    int bad   = 0;

    logic [3:0] raddrs [16];
    logic [7:0] exp_a  [16];
    logic [7:0] exp_b  [16];

    pipelined_memory #(.DEPTH(4), .BIT_SIZE(8), .READ_LATENCY(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_addr(write_addr),
        .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr), .clear(clear),
        .data_out(dout_a), .data_valid(dv_a), .ready(ready_a)
    );

    pipelined_memory #(.DEPTH(4), .BIT_SIZE(8), .READ_LATENCY(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_addr(write_addr),
        .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr), .clear(clear),
        .data_out(dout_b), .data_valid(dv_b), .ready(ready_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                 input logic re, input logic [3:0] ra, input logic cl);
        write_enable = we;
        write_addr   = wa;
        data_in      = wd;
        read_enable  = re;
        read_addr    = ra;
        clear        = cl;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with ready low, bounded.
    task automatic countLow(output int cnt);
        cnt = 0;
        while (!ready_a && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    // Issue n back-to-back reads from raddrs; optional write in the first read cycle.
    task automatic runReads(input int n, input logic wr0, input logic [3:0] wa0, input logic [7:0] wd0);
        for (int k = 0; k <= n + 1; k++) begin
            bit va, vb;
            if (k < n) applyStimulus(wr0 && (k == 0), wa0, wd0, 1'b1, raddrs[k], 1'b0);
            else       applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
            va = (k >= 2) && (k - 2 < n);
            vb = (k >= 1) && (k - 1 < n);
            checkOutput($sformatf("dv_a[%0d]", k), {31'b0, dv_a}, {31'b0, va});
            checkOutput($sformatf("dv_b[%0d]", k), {31'b0, dv_b}, {31'b0, vb});
            if (va) checkOutput($sformatf("dout_a[%0d]", k), {24'b0, dout_a}, {24'b0, exp_a[k-2]});
            if (vb) checkOutput($sformatf("dout_b[%0d]", k), {24'b0, dout_b}, {24'b0, exp_b[k-1]});
            step();
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);

        // Reset state
        step();
        checkOutput("rst_ready", {31'b0, ready_a}, 32'd0);
        checkOutput("rst_dv_a", {31'b0, dv_a}, 32'd0);
        checkOutput("rst_dout_a", {24'b0, dout_a}, 32'd0);
        checkOutput("rst_dv_b", {31'b0, dv_b}, 32'd0);

        // Initial clear sweep, then all addresses read as zero
        rst_n = 1'b1;
        countLow(cnt);
        checkOutput("init_clear_len", cnt, 32'd16);
        checkOutput("init_ready_b", {31'b0, ready_b}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            raddrs[i] = 4'(i);
            exp_a[i]  = 8'h00;
            exp_b[i]  = 8'h00;
        end
        runReads(16, 1'b0, 4'h0, 8'h00);

        // Write then read next cycle
        applyStimulus(1'b1, 4'd3, 8'hA5, 1'b0, 4'h0, 1'b0);
        step();
        raddrs[0] = 4'd3; exp_a[0] = 8'hA5; exp_b[0] = 8'hA5;
        runReads(1, 1'b0, 4'h0, 8'h00);

        // Same-address collision: A forwards new data, B returns old
        applyStimulus(1'b1, 4'd5, 8'h11, 1'b0, 4'h0, 1'b0);
        step();
        raddrs[0] = 4'd5; exp_a[0] = 8'h22; exp_b[0] = 8'h11;
        runReads(1, 1'b1, 4'd5, 8'h22);
        exp_b[0] = 8'h22;
        runReads(1, 1'b0, 4'h0, 8'h00);

        // Fill with i+0x40 and stream reads back-to-back
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 8'(i + 8'h40), 1'b0, 4'h0, 1'b0);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            raddrs[i] = 4'(i);
            exp_a[i]  = 8'(i + 8'h40);
            exp_b[i]  = 8'(i + 8'h40);
        end
        runReads(16, 1'b0, 4'h0, 8'h00);

        // Clear pulse with an in-flight read; writes and reads attempted throughout the sweep
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b1, 4'd7, 1'b1);
        step();
        applyStimulus(1'b1, 4'd2, 8'hFF, 1'b1, 4'd2, 1'b0);
        cnt = 0;
        while (!ready_a && cnt < 100) begin
            cnt++;
            checkOutput($sformatf("clr_dv_a[%0d]", cnt), {31'b0, dv_a}, {31'b0, cnt == 2});
            checkOutput($sformatf("clr_dv_b[%0d]", cnt), {31'b0, dv_b}, {31'b0, cnt == 1});
            if (cnt == 2) checkOutput("clr_inflight_a", {24'b0, dout_a}, 32'h47);
            if (cnt == 1) checkOutput("clr_inflight_b", {24'b0, dout_b}, 32'h47);
            step();
        end
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
        checkOutput("clr_len", cnt, 32'd16);
        raddrs[0] = 4'd2; exp_a[0] = 8'h00; exp_b[0] = 8'h00;
        runReads(1, 1'b0, 4'h0, 8'h00);

        // Put known data back, check hold when no read completes
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 8'(i + 8'h40), 1'b0, 4'h0, 1'b0);
            step();
        end
        raddrs[0] = 4'd9; exp_a[0] = 8'h49; exp_b[0] = 8'h49;
        runReads(1, 1'b0, 4'h0, 8'h00);
        checkOutput("hold_dv_a", {31'b0, dv_a}, 32'd0);
        checkOutput("hold_dout_a", {24'b0, dout_a}, 32'h49);
        checkOutput("hold_dout_b", {24'b0, dout_b}, 32'h49);

        // Reset in the middle of a clear sweep at counter 7
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {31'b0, ready_a}, 32'd0);
        checkOutput("mid_rst_dv_a", {31'b0, dv_a}, 32'd0);
        checkOutput("mid_rst_dout_a", {24'b0, dout_a}, 32'd0);
        checkOutput("mid_rst_dout_b", {24'b0, dout_b}, 32'd0);
        #1;
        rst_n = 1'b1;
        countLow(cnt);
        checkOutput("mid_rst_clear_len", cnt, 32'd16);
        raddrs[0] = 4'd9; exp_a[0] = 8'h00; exp_b[0] = 8'h00;
        runReads(1, 1'b0, 4'h0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
